screen_fader: RTL and testbench

- Downstream stage of every screen controller (start, game, end screens). It consumes the registered game_if stream and drives the VGA output stream.
- Applies a per-frame brightness ramp so screen changes fade out to black and back in; the top level performs the screen swap while the output is black.
- Outside a fade it is a 1-cycle registered pass-through, with RGB forced to 0 during blanking.

---
 rtl/screen_fader_pkg.sv | 20 ++
 rtl/screen_fader_if.sv | 27 ++
 rtl/screen_fader_scale.sv | 41 ++++
 rtl/screen_fader.sv | 156 +++++++++++++++
 tb/tb_screen_fader.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/screen_fader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : screen_fader_pkg
// Description : Shared constants and types for the screen fader stage.
// Revision    : 1.0 - initial release
// ============================================================================
package screen_fader_pkg;

    // Full-brightness level; levels run 0 (dark) .. FADE_LEVEL_MAX (unchanged).
    localparam int unsigned FADE_LEVEL_MAX = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        BLACK    = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_t;

endpackage : screen_fader_pkg
`default_nettype wire

// File: rtl/screen_fader_if.sv
`default_nettype none
// ============================================================================
// Module      : game_if
// Description : Video timing plus 12-bit RGB stream passed between screen
//               stages. "out" is the driving side, "in" the consuming side.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_if;

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport out (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

endinterface : game_if
`default_nettype wire

// File: rtl/screen_fader_scale.sv
`default_nettype none
// ============================================================================
// Module      : fade_scale
// Description : Combinational brightness scaler for one 4-bit colour channel.
//               Default build fades toward black: c * level >> 4.
//               With SCREEN_FADER_WHITE_EN defined it fades toward white:
//               c + ((15 - c) * (16 - level) >> 4).
// Revision    : 1.0 - initial release
// ============================================================================
module fade_scale
    import screen_fader_pkg::*;
(
    input  wire logic [3:0] ch_i,
    input  wire logic [4:0] level_i,
    output logic      [3:0] ch_o
);

`ifdef SCREEN_FADER_WHITE_EN
    logic [3:0] w_headroom;
    logic [4:0] w_inv_level;
    logic [8:0] w_prod;

    // Distance to full white, scaled by how far the fade has progressed.
    always_comb begin
        w_headroom  = 4'hF - ch_i;
        w_inv_level = 5'(FADE_LEVEL_MAX) - level_i;
        w_prod      = {5'b0, w_headroom} * {4'b0, w_inv_level};
        ch_o        = ch_i + 4'(w_prod >> 4);
    end
`else
    logic [8:0] w_prod;

    // Level 16 multiplies by 16, so bits [7:4] return the channel unchanged.
    always_comb begin
        w_prod = {5'b0, ch_i} * {4'b0, level_i};
        ch_o   = 4'(w_prod >> 4);
    end
`endif

endmodule : fade_scale
`default_nettype wire

// File: rtl/screen_fader.sv
`default_nettype none
// ============================================================================
// Module      : screen_fader
// Description : Final video stage. Registers the game_if stream by one clock
//               and applies a per-frame brightness ramp for screen changes:
//               fade_req fades out, BLACK holds while the screen is swapped,
//               screen_ready fades back in. RGB is zero during blanking.
//               Optional macro: SCREEN_FADER_WHITE_EN (fade toward white).
// Revision    : 1.0 - initial release
// ============================================================================
module screen_fader
    import screen_fader_pkg::*;
#(
    parameter int unsigned STEP_FRAMES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    game_if.in        in,
    game_if.out       out,
    input  wire logic fade_req,
    input  wire logic screen_ready,
    output logic      black,
    output logic      busy
);

    localparam logic [7:0] C_CNT_LAST  = 8'(STEP_FRAMES - 1);
    localparam logic [4:0] C_LEVEL_MAX = 5'(FADE_LEVEL_MAX);

    fade_state_t state_q, state_d;
    logic [4:0]  level_q, level_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        vblnk_prev_q;

    logic        w_tick;
    logic        w_step;
    logic        w_blank;
    logic [11:0] w_rgb_scaled;

    assign w_tick  = in.vblnk & ~vblnk_prev_q;
    assign w_step  = w_tick && (frame_cnt_q == C_CNT_LAST);
    assign w_blank = in.hblnk | in.vblnk;

    assign black = (state_q == BLACK);
    assign busy  = (state_q != IDLE);

    // Edge detector for the start of vertical blanking; reset high so the
    // first cycle out of reset never produces a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev_q <= 1'b1;
        end else begin
            vblnk_prev_q <= in.vblnk;
        end
    end

    // FSM, level and frame counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            level_q     <= C_LEVEL_MAX;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state logic. A state change always clears the frame counter,
    // even if a tick arrives on the same cycle.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            IDLE: begin
                level_d = C_LEVEL_MAX;
                if (fade_req) begin
                    state_d     = FADE_OUT;
                    frame_cnt_d = 8'd0;
                end
            end

            FADE_OUT: begin
                if (w_step) begin
                    frame_cnt_d = 8'd0;
                    level_d     = level_q - 5'd1;
                    if (level_q == 5'd1) begin
                        state_d = BLACK;
                    end
                end else if (w_tick) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end

            BLACK: begin
                level_d = 5'd0;
                if (screen_ready) begin
                    state_d     = FADE_IN;
                    frame_cnt_d = 8'd0;
                end
            end

            FADE_IN: begin
                if (w_step) begin
                    frame_cnt_d = 8'd0;
                    level_d     = level_q + 5'd1;
                    if (level_q == C_LEVEL_MAX - 5'd1) begin
                        state_d = IDLE;
                    end
                end else if (w_tick) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d     = IDLE;
                level_d     = C_LEVEL_MAX;
                frame_cnt_d = 8'd0;
            end
        endcase
    end

    // One scaler per colour channel: [11:8] R, [7:4] G, [3:0] B.
    for (genvar g = 0; g < 3; g++) begin : g_chan
        fade_scale u_scale (
            .ch_i    (in.rgb[4*g +: 4]),
            .level_i (level_q),
            .ch_o    (w_rgb_scaled[4*g +: 4])
        );
    end

    // Output register: timing delayed one clock, RGB scaled and blanked.
    always_ff @(posedge clk) begin
        if (rst) begin
            out.hcount <= 11'd0;
            out.vcount <= 11'd0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= 12'd0;
        end else begin
            out.hcount <= in.hcount;
            out.vcount <= in.vcount;
            out.hsync  <= in.hsync;
            out.vsync  <= in.vsync;
            out.hblnk  <= in.hblnk;
            out.vblnk  <= in.vblnk;
            out.rgb    <= w_blank ? 12'd0 : w_rgb_scaled;
        end
    end

endmodule : screen_fader
`default_nettype wire

// File: tb/tb_screen_fader.sv
`default_nettype none
// ============================================================================
// Module      : tb_screen_fader
// Description : Directed self-checking bench for screen_fader, STEP_FRAMES=1.
//               Expected colours follow SCREEN_FADER_WHITE_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_screen_fader;

`ifdef SCREEN_FADER_WHITE_EN
    localparam logic [11:0] C_L8_FFF  = 12'hFFF;
    localparam logic [11:0] C_L8_ABC  = 12'hCDD;
    localparam logic [11:0] C_L4_888  = 12'hDDD;
    localparam logic [11:0] C_L4_FFF  = 12'hFFF;
    localparam logic [11:0] C_L0_FFF  = 12'hFFF;
    localparam logic [11:0] C_L0_000  = 12'hFFF;
    localparam logic [11:0] C_L15_FFF = 12'hFFF;
    localparam logic [11:0] C_L5_FFF  = 12'hFFF;
`else
    localparam logic [11:0] C_L8_FFF  = 12'h777;
    localparam logic [11:0] C_L8_ABC  = 12'h556;
    localparam logic [11:0] C_L4_888  = 12'h222;
    localparam logic [11:0] C_L4_FFF  = 12'h333;
    localparam logic [11:0] C_L0_FFF  = 12'h000;
    localparam logic [11:0] C_L0_000  = 12'h000;
    localparam logic [11:0] C_L15_FFF = 12'hEEE;
    localparam logic [11:0] C_L5_FFF  = 12'h444;
`endif

    logic clk;
    logic rst;
    logic fade_req;
    logic screen_ready;
    logic black;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    game_if u_src ();
    game_if u_dst ();

    screen_fader #(.STEP_FRAMES(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .in           (u_src.in),
        .out          (u_dst.out),
        .fade_req     (fade_req),
        .screen_ready (screen_ready),
        .black        (black),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame tick: vblnk rises for a cycle, then drops.
    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            u_src.vblnk = 1'b1;
            step();
            u_src.vblnk = 1'b0;
            step();
        end
    endtask

    task automatic pixel(input logic [11:0] c);
        u_src.hblnk = 1'b0;
        u_src.vblnk = 1'b0;
        u_src.rgb   = c;
        step();
    endtask

    task automatic pulse(input logic fr, input logic sr);
        fade_req     = fr;
        screen_ready = sr;
        step();
        fade_req     = 1'b0;
        screen_ready = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        fade_req     = 1'b0;
        screen_ready = 1'b0;
        u_src.hcount = 11'd7;
        u_src.vcount = 11'd9;
        u_src.hsync  = 1'b1;
        u_src.vsync  = 1'b1;
        u_src.hblnk  = 1'b0;
        u_src.vblnk  = 1'b0;
        u_src.rgb    = 12'hFFF;
        repeat (3) step();

        check_eq("rst_busy",   32'(busy),         32'd0);
        check_eq("rst_black",  32'(black),        32'd0);
        check_eq("rst_rgb",    32'(u_dst.rgb),    32'd0);
        check_eq("rst_hcount", 32'(u_dst.hcount), 32'd0);
        check_eq("rst_hsync",  32'(u_dst.hsync),  32'd0);
        rst = 1'b0;

        // Idle pass-through with one-clock timing delay.
        u_src.hcount = 11'd123;
        u_src.vcount = 11'd45;
        u_src.hsync  = 1'b1;
        u_src.vsync  = 1'b0;
        pixel(12'hABC);
        check_eq("pt_hcount", 32'(u_dst.hcount), 32'd123);
        check_eq("pt_vcount", 32'(u_dst.vcount), 32'd45);
        check_eq("pt_hsync",  32'(u_dst.hsync),  32'd1);
        check_eq("pt_vsync",  32'(u_dst.vsync),  32'd0);
        check_eq("pt_rgb",    32'(u_dst.rgb),    32'hABC);

        u_src.hcount = 11'd124;
        u_src.hblnk  = 1'b1;
        step();
        check_eq("hblnk_rgb",    32'(u_dst.rgb),    32'd0);
        check_eq("hblnk_flag",   32'(u_dst.hblnk),  32'd1);
        check_eq("hblnk_hcount", 32'(u_dst.hcount), 32'd124);
        u_src.hblnk = 1'b0;

        // screen_ready in IDLE is ignored.
        pulse(1'b0, 1'b1);
        check_eq("sr_idle_busy",  32'(busy),  32'd0);
        check_eq("sr_idle_black", 32'(black), 32'd0);

        // fade_req and screen_ready together in IDLE: fade wins.
        pulse(1'b1, 1'b1);
        check_eq("fo_busy",  32'(busy),  32'd1);
        check_eq("fo_black", 32'(black), 32'd0);
        pixel(12'hFFF);
        check_eq("fo_l16", 32'(u_dst.rgb), 32'hFFF);

        do_ticks(8);
        pixel(12'hFFF);
        check_eq("fo_l8_fff", 32'(u_dst.rgb), 32'(C_L8_FFF));
        pixel(12'hABC);
        check_eq("fo_l8_abc", 32'(u_dst.rgb), 32'(C_L8_ABC));

        do_ticks(4);
        pixel(12'h888);
        check_eq("fo_l4_888", 32'(u_dst.rgb), 32'(C_L4_888));
        pixel(12'hFFF);
        check_eq("fo_l4_fff", 32'(u_dst.rgb), 32'(C_L4_FFF));

        do_ticks(3);
        check_eq("fo_l1_black", 32'(black), 32'd0);
        do_ticks(1);
        check_eq("fo_done_black", 32'(black), 32'd1);
        check_eq("fo_done_busy",  32'(busy),  32'd1);
        pixel(12'hFFF);
        check_eq("blk_fff", 32'(u_dst.rgb), 32'(C_L0_FFF));
        pixel(12'h000);
        check_eq("blk_000", 32'(u_dst.rgb), 32'(C_L0_000));

        // fade_req in BLACK is ignored.
        pulse(1'b1, 1'b0);
        check_eq("blk_fr_black", 32'(black), 32'd1);

        // Fade-in.
        pulse(1'b0, 1'b1);
        check_eq("fi_black", 32'(black), 32'd0);
        check_eq("fi_busy",  32'(busy),  32'd1);
        pixel(12'hFFF);
        check_eq("fi_l0", 32'(u_dst.rgb), 32'(C_L0_FFF));

        do_ticks(8);
        pulse(1'b1, 1'b0);
        check_eq("fi_fr_busy",  32'(busy),  32'd1);
        check_eq("fi_fr_black", 32'(black), 32'd0);
        pixel(12'hFFF);
        check_eq("fi_l8_fff", 32'(u_dst.rgb), 32'(C_L8_FFF));

        do_ticks(7);
        check_eq("fi_l15_busy", 32'(busy), 32'd1);
        pixel(12'hFFF);
        check_eq("fi_l15_fff", 32'(u_dst.rgb), 32'(C_L15_FFF));

        do_ticks(1);
        check_eq("fi_done_busy", 32'(busy), 32'd0);
        pixel(12'hABC);
        check_eq("fi_done_rgb", 32'(u_dst.rgb), 32'hABC);

        // Reset in the middle of a fade-out at level 5.
        pulse(1'b1, 1'b0);
        do_ticks(11);
        pixel(12'hFFF);
        check_eq("mid_l5_fff", 32'(u_dst.rgb), 32'(C_L5_FFF));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_busy",  32'(busy),  32'd0);
        check_eq("mid_rst_black", 32'(black), 32'd0);
        pixel(12'hFFF);
        check_eq("mid_rst_rgb", 32'(u_dst.rgb), 32'hFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_screen_fader
`default_nettype wire
